// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: reads 384-bit color words back from the CW SRAM and
// serializes them into a one-pixel-per-cycle valid/ready stream with line/frame markers.
module frame_buffer_reader #(
  parameter int ADDR_W    = 16,
  parameter int PIX_W     = 24,
  parameter int PIX_PER_W = 16,
  parameter int LINE_W    = 640
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          num_words,
  output logic                       sram_rd_en,
  output logic [ADDR_W-1:0]          sram_addr,
  input  logic [PIX_W*PIX_PER_W-1:0] sram_rdata,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [PIX_W-1:0]           pix_rgb,
  output logic                       pix_eol,
  output logic                       pix_last,
  output logic                       busy,
  output logic                       done
);

  localparam int WORD_W = PIX_W * PIX_PER_W;
  localparam int CNT_W  = ADDR_W + 4;
  localparam int SH_W   = $clog2(PIX_PER_W + 1);
  localparam int X_W    = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_num_words;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic               r_inflight;
  logic               r_pf_valid;
  logic [WORD_W-1:0]  r_pf_data;
  logic [WORD_W-1:0]  r_sh_data;
  logic [SH_W-1:0]    r_sh_left;
  logic [X_W-1:0]     r_line_x;
  logic [CNT_W-1:0]   r_pix_cnt;
  logic [CNT_W-1:0]   r_last_idx;
  logic               w_xfer;
  logic               w_sh_free;
  logic               w_rd_en;
  logic               w_start;

  // Every pixel-side output comes straight from registers, so pix_valid never
  // depends combinationally on pix_ready and stalled values stay put.
  assign pix_valid  = (r_sh_left != '0);
  assign pix_rgb    = r_sh_data[PIX_W-1:0];
  assign pix_eol    = pix_valid & (r_line_x == X_W'(LINE_W - 1));
  assign pix_last   = pix_valid & (r_pix_cnt == r_last_idx);
  assign sram_rd_en = w_rd_en;
  assign sram_addr  = r_rd_addr;

  assign w_xfer    = pix_valid & pix_ready;
  assign w_sh_free = (r_sh_left == '0) | (w_xfer & (r_sh_left == SH_W'(1)));
  assign w_start   = (r_state == S_IDLE) & start;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (num_words == '0) ? S_FIN : S_RUN;
      S_RUN: begin
        busy    = 1'b1;
        w_rd_en = !r_inflight & (!r_pf_valid | w_sh_free) & (r_rd_addr < r_num_words);
        if (w_xfer & pix_last) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the word buffers are reset too; pix_rgb is driven from them and must read 0 in reset.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_state     <= S_IDLE;
      r_num_words <= '0;
      r_rd_addr   <= '0;
      r_inflight  <= 1'b0;
      r_pf_valid  <= 1'b0;
      r_pf_data   <= '0;
      r_sh_data   <= '0;
      r_sh_left   <= '0;
      r_line_x    <= '0;
      r_pix_cnt   <= '0;
      r_last_idx  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;

      if (w_start) begin
        r_num_words <= num_words;
        r_rd_addr   <= '0;
        r_line_x    <= '0;
        r_pix_cnt   <= '0;
        r_last_idx  <= CNT_W'(num_words) * CNT_W'(PIX_PER_W) - CNT_W'(1);
      end else begin
        if (w_rd_en) r_rd_addr <= r_rd_addr + ADDR_W'(1);
        if (w_xfer) begin
          r_pix_cnt <= r_pix_cnt + CNT_W'(1);
          r_line_x  <= (r_line_x == X_W'(LINE_W - 1)) ? '0 : r_line_x + X_W'(1);
        end
      end

      // Shift register: refill from prefetch first, else straight from SRAM.
      if (w_sh_free & r_pf_valid) begin
        r_sh_data <= r_pf_data;
        r_sh_left <= SH_W'(PIX_PER_W);
      end else if (w_sh_free & r_inflight) begin
        r_sh_data <= sram_rdata;
        r_sh_left <= SH_W'(PIX_PER_W);
      end else if (w_xfer) begin
        r_sh_data <= r_sh_data >> PIX_W;
        r_sh_left <= r_sh_left - SH_W'(1);
      end

      if (r_inflight & !(w_sh_free & !r_pf_valid)) begin
        r_pf_data  <= sram_rdata;
        r_pf_valid <= 1'b1;
      end else if (w_sh_free) begin
        r_pf_valid <= 1'b0;
      end
    end
  end

endmodule
